// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable width, parity and stop bits.
// Every bit is a 3-sample majority vote; words leave through one valid/ready holding register.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int N_STOP     = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break,
  output logic               o_overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(NB_DATA);
  localparam logic [SW-1:0] S_SAMP0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_SAMP1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_SAMP2     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST_DATA = NW'(NB_DATA - 1);
  localparam logic [NW-1:0] N_LAST_STOP = NW'(N_STOP - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state;
  state_t             state_next;
  logic               rx_meta;
  logic               rx_sync;
  logic [SW-1:0]      s;
  logic [NW-1:0]      n;
  logic [NB_DATA-1:0] shreg;
  logic [2:0]         samp;
  logic               par_bit;
  logic               stop_err;
  logic               vote_mid;
  logic               vote_end;
  logic               frame_done;
  logic               done_ferr;
  logic               done_perr;
  logic               done_brk;

  // Both synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (i_tick && !rx_sync) state_next = START;
      START:  if (i_tick) begin
                if ((s == S_SAMP2) && vote_mid) state_next = IDLE;
                else if (s == S_LAST)          state_next = DATA;
              end
      DATA:   if (i_tick && (s == S_LAST) && (n == N_LAST_DATA))
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (i_tick && (s == S_LAST)) state_next = STOP;
      STOP:   if (frame_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The last stop bit is judged at the third sample point so the line has half a bit to settle.
  always_comb begin
    vote_mid   = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
    vote_end   = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    frame_done = i_tick && (state == STOP) && (s == S_SAMP2) && (n == N_LAST_STOP);
    done_ferr  = stop_err | ~vote_mid;
    done_perr  = (PARITY_EN != 0) && ((^shreg) ^ par_bit ^ (PARITY_ODD != 0));
    done_brk   = done_ferr && (shreg == '0) && ((PARITY_EN == 0) || !par_bit);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s        <= '0;
      n        <= '0;
      shreg    <= '0;
      samp     <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
    end else if (i_tick) begin
      if (s == S_SAMP0) samp[0] <= rx_sync;
      if (s == S_SAMP1) samp[1] <= rx_sync;
      if (s == S_SAMP2) samp[2] <= rx_sync;
      case (state)
        IDLE: begin
          s        <= '0;
          n        <= '0;
          stop_err <= 1'b0;
        end
        START: begin
          n <= '0;
          s <= (s == S_LAST) ? '0 : s + 1'b1;
        end
        DATA: begin
          if (s == S_LAST) begin
            shreg <= {vote_end, shreg[NB_DATA-1:1]};
            s     <= '0;
            n     <= (n == N_LAST_DATA) ? '0 : n + 1'b1;
          end else begin
            s <= s + 1'b1;
          end
        end
        PARITY: begin
          if (s == S_LAST) begin
            par_bit <= vote_end;
            s       <= '0;
          end else begin
            s <= s + 1'b1;
          end
        end
        STOP: begin
          if (frame_done) begin
            s <= '0;
            n <= '0;
          end else if (s == S_LAST) begin
            stop_err <= stop_err | ~vote_end;
            s        <= '0;
            n        <= n + 1'b1;
          end else begin
            s <= s + 1'b1;
          end
        end
        default: begin
          s <= '0;
          n <= '0;
        end
      endcase
    end
  end

  // A completed frame loads only if the register is empty or being drained this very cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_break <= 1'b0;
      if (frame_done) begin
        o_break <= done_brk;
        if (!o_valid || i_ready) begin
          o_valid      <= 1'b1;
          o_data       <= shreg;
          o_parity_err <= done_perr;
          o_frame_err  <= done_ferr;
          if (o_valid) o_overrun <= 1'b0;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: drives 8E1, 8O1 and 8N2 receivers from shared baud ticks and checks
// delivered words against constant tables and a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr_even;
    logic       exp_perr_odd;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_tick  = 1'b0;
  logic i_ready = 1'b1;
  logic rx_a    = 1'b1;
  logic rx_b    = 1'b1;
  int   tick_div = 0;

  logic       valid_e, perr_e, ferr_e, brk_e, ovr_e;
  logic       valid_o, perr_o, ferr_o, brk_o, ovr_o;
  logic       valid_s, perr_s, ferr_s, brk_s, ovr_s;
  logic [7:0] data_e, data_o, data_s;

  int checks = 0;
  int errors = 0;

  word_t log_e[$];
  word_t log_o[$];
  word_t log_s[$];
  int    brk_e_cnt = 0, brk_o_cnt = 0, brk_s_cnt = 0, vcyc_e = 0;
  int    rd_e = 0, rd_o = 0, rd_s = 0;
  int    brk_e_seen = 0, brk_o_seen = 0, brk_s_seen = 0, vcyc_seen = 0;

  uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(OS), .N_STOP(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_a), .i_ready(i_ready),
    .o_valid(valid_e), .o_data(data_e), .o_parity_err(perr_e), .o_frame_err(ferr_e),
    .o_break(brk_e), .o_overrun(ovr_e)
  );

  uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(OS), .N_STOP(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_a), .i_ready(i_ready),
    .o_valid(valid_o), .o_data(data_o), .o_parity_err(perr_o), .o_frame_err(ferr_o),
    .o_break(brk_o), .o_overrun(ovr_o)
  );

  uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(OS), .N_STOP(2), .PARITY_EN(0), .PARITY_ODD(0)) u_s2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_b), .i_ready(i_ready),
    .o_valid(valid_s), .o_data(data_s), .o_parity_err(perr_s), .o_frame_err(ferr_s),
    .o_break(brk_s), .o_overrun(ovr_s)
  );

  always #5 i_clock = ~i_clock;

  // One baud tick every third clock keeps tick and clock phases distinct.
  always @(posedge i_clock) begin
    tick_div <= (tick_div == 2) ? 0 : tick_div + 1;
    i_tick   <= (tick_div == 2);
  end

  always @(negedge i_clock) begin
    if (valid_e && i_ready) log_e.push_back({data_e, perr_e, ferr_e});
    if (valid_o && i_ready) log_o.push_back({data_o, perr_o, ferr_o});
    if (valid_s && i_ready) log_s.push_back({data_s, perr_s, ferr_s});
    if (brk_e) brk_e_cnt++;
    if (brk_o) brk_o_cnt++;
    if (brk_s) brk_s_cnt++;
    if (valid_e) vcyc_e++;
  end

  initial begin
    #800000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_rx(input bit line, input logic v);
    if (line) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic wait_ticks(input int cnt);
    int k = 0;
    while (k < cnt) begin
      @(posedge i_clock);
      if (i_tick) k++;
    end
    #1;
  endtask

  // Holds one bit for a full bit period; a glitch flips the line for one tick near mid-bit.
  task automatic send_bit(input bit line, input logic v, input bit glitch);
    int k = 0;
    set_rx(line, v);
    while (k < OS) begin
      @(posedge i_clock);
      if (i_tick) begin
        k++;
        if (glitch && k == 9)  begin #1; set_rx(line, ~v); end
        if (glitch && k == 10) begin #1; set_rx(line, v);  end
      end
    end
    #1;
  endtask

  task automatic apply_stimulus(input bit line, input logic [7:0] d, input logic p,
                                input logic [1:0] stops, input bit glitch_last);
    send_bit(line, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(line, d[i], 1'b0);
    if (!line) begin
      send_bit(1'b0, p, 1'b0);
      send_bit(1'b0, stops[0], glitch_last);
    end else begin
      send_bit(1'b1, stops[0], 1'b0);
      send_bit(1'b1, stops[1], glitch_last);
    end
    set_rx(line, 1'b1);
  endtask

  task automatic sync_mon();
    rd_e = log_e.size();
    rd_o = log_o.size();
    rd_s = log_s.size();
    brk_e_seen = brk_e_cnt;
    brk_o_seen = brk_o_cnt;
    brk_s_seen = brk_s_cnt;
    vcyc_seen  = vcyc_e;
  endtask

  // Frame-level reference: parity from the count of ones, break from an all-zero frame body.
  function automatic void model_frame(input logic [7:0] d, input logic p, input logic st,
                                      output logic pe_even, output logic pe_odd,
                                      output logic fe, output logic bk);
    int ones;
    ones    = $countones({d, p});
    pe_even = (ones % 2) != 0;
    pe_odd  = (ones % 2) == 0;
    fe      = !st;
    bk      = fe && (d == 8'h00) && !p;
  endfunction

  task automatic check_frame_a(input string tag, input logic [7:0] ed, input logic epe,
                               input logic epo, input logic efe, input logic ebk);
    word_t we, wo;
    we = (log_e.size() > rd_e) ? log_e[rd_e] : '1;
    wo = (log_o.size() > rd_o) ? log_o[rd_o] : '1;
    check_output({tag, "_cnt_even"}, log_e.size() - rd_e, 1);
    check_output({tag, "_cnt_odd"}, log_o.size() - rd_o, 1);
    check_output({tag, "_data"}, 32'(we.data), 32'(ed));
    check_output({tag, "_perr_even"}, 32'(we.perr), 32'(epe));
    check_output({tag, "_perr_odd"}, 32'(wo.perr), 32'(epo));
    check_output({tag, "_ferr"}, 32'(we.ferr), 32'(efe));
    check_output({tag, "_brk_even"}, brk_e_cnt - brk_e_seen, 32'(ebk));
    check_output({tag, "_brk_odd"}, brk_o_cnt - brk_o_seen, 32'(ebk));
    check_output({tag, "_valid_cycles"}, vcyc_e - vcyc_seen, 1);
    sync_mon();
  endtask

  task automatic check_frame_b(input string tag, input logic [7:0] ed, input logic efe, input logic ebk);
    word_t ws;
    ws = (log_s.size() > rd_s) ? log_s[rd_s] : '1;
    check_output({tag, "_cnt"}, log_s.size() - rd_s, 1);
    check_output({tag, "_data"}, 32'(ws.data), 32'(ed));
    check_output({tag, "_ferr"}, 32'(ws.ferr), 32'(efe));
    check_output({tag, "_brk"}, brk_s_cnt - brk_s_seen, 32'(ebk));
    sync_mon();
  endtask

  initial begin
    vec_t       vecs[8];
    word_t      w0, w1;
    logic [7:0] d;
    logic       p, st, epe, epo, efe, ebk;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (4) @(posedge i_clock);
    @(negedge i_clock);
    check_output("reset_even", 32'({valid_e, data_e, perr_e, ferr_e, brk_e, ovr_e}), 0);
    check_output("reset_odd", 32'({valid_o, data_o, perr_o, ferr_o, brk_o, ovr_o}), 0);
    check_output("reset_s2", 32'({valid_s, data_s, perr_s, ferr_s, brk_s, ovr_s}), 0);
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    wait_ticks(OS);
    sync_mon();

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, vecs[i].data, vecs[i].par, {1'b1, vecs[i].stop}, 1'b0);
      wait_ticks(2 * OS);
      check_frame_a($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_perr_even,
                    vecs[i].exp_perr_odd, vecs[i].exp_ferr, vecs[i].exp_brk);
    end

    $display("[TB] false start glitch");
    rx_a = 1'b0;
    wait_ticks(4);
    rx_a = 1'b1;
    wait_ticks(3 * OS);
    check_output("glitch_no_word", log_e.size() - rd_e, 0);
    check_output("glitch_no_valid", vcyc_e - vcyc_seen, 0);
    apply_stimulus(1'b0, 8'h55, 1'b0, 2'b11, 1'b0);
    wait_ticks(2 * OS);
    check_frame_a("after_glitch", 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] two stop bits");
    apply_stimulus(1'b1, 8'h00, 1'b0, 2'b01, 1'b0);
    wait_ticks(2 * OS);
    check_frame_b("s2_break", 8'h00, 1'b1, 1'b1);
    apply_stimulus(1'b1, 8'h5A, 1'b0, 2'b11, 1'b1);
    wait_ticks(2 * OS);
    check_frame_b("s2_stop_glitch", 8'h5A, 1'b0, 1'b0);

    $display("[TB] overrun");
    i_ready = 1'b0;
    apply_stimulus(1'b0, 8'h11, 1'b0, 2'b11, 1'b0);
    wait_ticks(2 * OS);
    apply_stimulus(1'b0, 8'h22, 1'b0, 2'b11, 1'b0);
    wait_ticks(2 * OS);
    @(negedge i_clock);
    check_output("ovr_valid", 32'(valid_e), 1);
    check_output("ovr_data_kept", 32'(data_e), 32'h11);
    check_output("ovr_perr_kept", 32'(perr_e), 0);
    check_output("ovr_flag_even", 32'(ovr_e), 1);
    check_output("ovr_flag_odd", 32'(ovr_o), 1);
    @(posedge i_clock);
    #1 i_ready = 1'b1;
    @(posedge i_clock);
    #1 i_ready = 1'b0;
    @(negedge i_clock);
    check_output("hs_valid_low", 32'(valid_e), 0);
    check_output("hs_ovr_clear", 32'(ovr_e), 0);
    i_ready = 1'b1;
    wait_ticks(OS);
    sync_mon();
    apply_stimulus(1'b0, 8'h01, 1'b1, 2'b11, 1'b0);
    apply_stimulus(1'b0, 8'h02, 1'b1, 2'b11, 1'b0);
    wait_ticks(2 * OS);
    w0 = (log_e.size() > rd_e) ? log_e[rd_e] : '1;
    w1 = (log_e.size() > rd_e + 1) ? log_e[rd_e + 1] : '1;
    check_output("b2b_count", log_e.size() - rd_e, 2);
    check_output("b2b_first", 32'(w0), 32'({8'h01, 1'b0, 1'b0}));
    check_output("b2b_second", 32'(w1), 32'({8'h02, 1'b0, 1'b0}));
    sync_mon();

    $display("[TB] reset mid-frame");
    i_ready = 1'b0;
    apply_stimulus(1'b0, 8'h33, 1'b0, 2'b11, 1'b0);
    wait_ticks(2 * OS);
    check_output("held_before_reset", 32'(valid_e), 1);
    d = 8'hF0;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, d[i], 1'b0);
    rx_a = d[4];
    wait_ticks(8);
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check_output("midreset_even", 32'({valid_e, data_e, perr_e, ferr_e, brk_e, ovr_e}), 0);
    check_output("midreset_odd", 32'({valid_o, data_o, perr_o, ferr_o, brk_o, ovr_o}), 0);
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    i_ready = 1'b1;
    wait_ticks(2 * OS);
    check_output("midreset_no_word", log_e.size() - rd_e, 0);
    check_output("midreset_valid_low", 32'(valid_e), 0);
    sync_mon();
    apply_stimulus(1'b0, 8'h0F, 1'b0, 2'b11, 1'b0);
    wait_ticks(2 * OS);
    check_frame_a("after_reset", 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) d = 8'h00;
      p  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) != 0);
      model_frame(d, p, st, epe, epo, efe, ebk);
      apply_stimulus(1'b0, d, p, {1'b1, st}, 1'b0);
      wait_ticks(2 * OS);
      check_frame_a($sformatf("rand%0d", i), d, epe, epo, efe, ebk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
